// File: rtl/riscv_pkg.sv
// riscv_pkg: FSM state encodings, opcode constants and hazard helpers shared by the stall controller
// Ports: none (package only)
package riscv_pkg;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL2 = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef struct packed {
    logic load_use;
    logic br_ex;
    logic br_load1;
    logic br_load2;
  } hazard_t;
  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OP_R || op == OP_STORE || op == OP_BRANCH;
  endfunction
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: pipeline-to-controller bundle
// Ports: master = pipeline side (drives IF/ID, ID/EX, EX/MEM fields), slave = controller (drives enables, stats, state)
interface hazard_stall_controller_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs1, id_rs2;
  logic [6:0]       id_opcode;
  logic             ex_memread, ex_regwrite;
  logic [4:0]       ex_rd;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic             branch_taken, mem_busy;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       fsm_state;
  modport master (
    output id_rs1, id_rs2, id_opcode, ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, branch_taken, mem_busy,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, stall_cnt, flush_cnt, fsm_state
  );
  modport slave (
    input  id_rs1, id_rs2, id_opcode, ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, branch_taken, mem_busy,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, stall_cnt, flush_cnt, fsm_state
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational register-match hazard classification for the ID stage
// Ports: i_* IF/ID, ID/EX and EX/MEM fields; o_load_use, o_br_ex, o_br_load1, o_br_load2 hazard flags
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [6:0] i_id_opcode,
  input  logic       i_ex_memread,
  input  logic       i_ex_regwrite,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_memread,
  input  logic [4:0] i_mem_rd,
  output logic       o_load_use,
  output logic       o_br_ex,
  output logic       o_br_load1,
  output logic       o_br_load2
);
  logic w_rs2, w_is_br, w_ex_hit, w_mem_hit;
  assign w_rs2      = uses_rs2(i_id_opcode);
  assign w_is_br    = i_id_opcode == OP_BRANCH;
  assign w_ex_hit   = i_ex_rd != 5'd0 && (i_ex_rd == i_id_rs1 || (w_rs2 && i_ex_rd == i_id_rs2));
  assign w_mem_hit  = i_mem_rd != 5'd0 && (i_mem_rd == i_id_rs1 || (w_rs2 && i_mem_rd == i_id_rs2));
  assign o_load_use = i_ex_memread && w_ex_hit && !w_is_br;
  assign o_br_ex    = w_is_br && i_ex_regwrite && !i_ex_memread && w_ex_hit;
  assign o_br_load1 = w_is_br && i_mem_memread && w_mem_hit;
  assign o_br_load2 = w_is_br && i_ex_memread && w_ex_hit;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush/hold control FSM with saturating statistics
// Ports: clk, rst_n (async active-low), bus (slave modport: hazard inputs in, enables/stats/state out)
module hazard_stall_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  hazard_stall_controller_if.slave bus
);
  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  hazard_t          w_haz;
  logic             w_hold, w_stall, w_flush;
  hazard_detect u_detect (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_opcode   (bus.id_opcode),
    .i_ex_memread  (bus.ex_memread),
    .i_ex_regwrite (bus.ex_regwrite),
    .i_ex_rd       (bus.ex_rd),
    .i_mem_memread (bus.mem_memread),
    .i_mem_rd      (bus.mem_rd),
    .o_load_use    (w_haz.load_use),
    .o_br_ex       (w_haz.br_ex),
    .o_br_load1    (w_haz.br_load1),
    .o_br_load2    (w_haz.br_load2)
  );
  // gating with rst_n keeps the pipeline free-running while reset is held
  always_comb begin
    w_hold  = rst_n && bus.mem_busy;
    w_stall = rst_n && !bus.mem_busy && (r_state == ST_STALL2 || w_haz != '0);
    w_flush = rst_n && !bus.mem_busy && !w_stall && bus.branch_taken;
    // leaving HOLD always lands in RUN, even if a two-cycle branch hazard is present
    w_next  = (r_state == ST_RUN && !bus.mem_busy && w_haz.br_load2) ? ST_STALL2 :
              (r_state != 2'd3 && bus.mem_busy) ? ST_HOLD : ST_RUN;
  end
  assign bus.pc_write     = !(w_hold || w_stall);
  assign bus.if_id_write  = !(w_hold || w_stall);
  assign bus.id_ex_bubble = w_stall;
  assign bus.if_id_flush  = w_flush;
  assign bus.pipe_hold    = w_hold;
  assign bus.fsm_state    = r_state;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule
